// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction ROM and
// registers the returned word into the IF/ID latch. Stall and redirect come
// from later stages. A misaligned or out-of-range PC raises a sticky fault and
// parks the stage in HALT until reset.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] ROM_BYTES = 64'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] rom_address,
  output logic        rom_cs,
  output logic        rom_oe,
  input  logic [63:0] rom_data,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic        rom_en_q, rom_en_d;
  logic        pc_bad;

  // Upper half of the ROM bus carries nothing for a 32-bit instruction word.
  logic unused_rom_hi;
  assign unused_rom_hi = ^rom_data[63:32];

  // Current PC is unusable if it is not word aligned or lies past the ROM.
  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q >= ROM_BYTES);

  // Next-state logic. Fault beats redirect, redirect beats stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    count_d    = count_q;
    rom_en_d   = rom_en_q;
    unique case (state_q)
      S_IDLE: begin
        // One settling cycle before the first capture; enable the ROM now so
        // it is selected for the whole of RUN.
        state_d  = S_RUN;
        rom_en_d = 1'b1;
      end
      S_RUN: begin
        if (pc_bad) begin
          if_valid_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = S_HALT;
          rom_en_d   = 1'b0;
        end else if (redirect) begin
          // The word fetched from the old path this cycle is dropped.
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d = rom_data[31:0];
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 64'd4;
          count_d    = count_q + 32'd1;
        end
      end
      S_HALT: begin
        rom_en_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: fail safe into the faulted state.
        state_d    = S_HALT;
        fault_d    = 1'b1;
        if_valid_d = 1'b0;
        rom_en_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= 64'h0;
      if_instr_q <= 32'h0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0;
      rom_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      rom_en_q   <= rom_en_d;
    end
  end

  assign rom_address = pc_q[31:0];
  assign rom_cs      = rom_en_q;
  assign rom_oe      = rom_en_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural fetch model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch;

  localparam logic [63:0] ROMB = 64'h24;

  logic        clock = 1'b0;
  logic        reset, stall, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] rom_address;
  logic        rom_cs, rom_oe;
  logic [63:0] rom_data;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid, fetch_fault;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_PC(64'h0), .ROM_BYTES(ROMB)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_address(rom_address), .rom_cs(rom_cs),
    .rom_oe(rom_oe), .rom_data(rom_data), .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  // Instruction ROM contents, word indexed.
  logic [31:0] rom [16];
  initial begin
    rom[0]  = 32'h910007E0; rom[1]  = 32'h910007E1; rom[2]  = 32'hF1003C04;
    rom[3]  = 32'h8B020021; rom[4]  = 32'hCB000042; rom[5]  = 32'h8B010000;
    rom[6]  = 32'hAA010002; rom[7]  = 32'h8A030044; rom[8]  = 32'hD61F03E0;
    rom[9]  = 32'h11111111; rom[10] = 32'h22222222; rom[11] = 32'h33333333;
    rom[12] = 32'h44444444; rom[13] = 32'h55555555; rom[14] = 32'h66666666;
    rom[15] = 32'h77777777;
  end

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    if (a < 64'h40) return rom[a[5:2]];
    return 32'hFFFF_FFFF;
  endfunction

  // Combinational ROM; garbage upper half, and garbage when deselected.
  always_comb begin
    rom_data = 64'hBAD0_BAD0_BAD0_BAD0;
    if (rom_cs && rom_oe)
      rom_data = {~rom_address, rom_word({32'h0, rom_address})};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must present after each edge.
  bit          m_ok = 0;
  int          m_phase;      // 0 settling after reset, 1 fetching, 2 halted
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_fault, m_en;

  always @(posedge clock) begin
    if (reset) begin
      m_ok = 1; m_phase = 0; m_pc = 64'h0; m_ifpc = 64'h0; m_instr = 32'h0;
      m_cnt = 32'h0; m_valid = 0; m_fault = 0; m_en = 0;
    end else if (m_ok) begin
      if (m_phase == 0) begin
        m_phase = 1; m_en = 1;
      end else if (m_phase == 1) begin
        if (m_pc[1:0] != 2'b00 || m_pc >= ROMB) begin
          m_valid = 0; m_fault = 1; m_phase = 2; m_en = 0;
        end else if (redirect) begin
          m_pc = redirect_pc; m_valid = 0;
        end else if (!stall) begin
          m_instr = rom_word(m_pc); m_ifpc = m_pc; m_valid = 1;
          m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, just after the edge.
  always @(posedge clock) begin
    #1;
    if (m_ok) begin
      chk("m_if_valid",    {63'h0, if_valid},    {63'h0, m_valid});
      chk("m_if_pc",       if_pc,                m_ifpc);
      chk("m_if_instr",    {32'h0, if_instr},    {32'h0, m_instr});
      chk("m_fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
      chk("m_fetch_count", {32'h0, fetch_count}, {32'h0, m_cnt});
      chk("m_rom_cs",      {63'h0, rom_cs},      {63'h0, m_en});
      chk("m_rom_oe",      {63'h0, rom_oe},      {63'h0, m_en});
      chk("m_rom_address", {32'h0, rom_address}, {32'h0, m_pc[31:0]});
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
    chk({tag, "_ifpc"},  if_pc, 64'h0);
    chk({tag, "_instr"}, {32'h0, if_instr}, 64'h0);
    chk({tag, "_count"}, {32'h0, fetch_count}, 64'h0);
    chk({tag, "_fault"}, {63'h0, fetch_fault}, 64'h0);
    chk({tag, "_cs"},    {63'h0, rom_cs}, 64'h0);
    chk({tag, "_oe"},    {63'h0, rom_oe}, 64'h0);
    chk({tag, "_addr"},  {32'h0, rom_address}, 64'h0);
  endtask

  initial begin
    bit done;
    reset = 1; stall = 0; redirect = 0; redirect_pc = 64'h0;
    repeat (3) tick();
    chk_reset_vals("rst0");

    // 1: free run from reset, IDLE cycle first.
    reset = 0;
    tick();
    chk("t1_idle_valid", {63'h0, if_valid}, 64'h0);
    chk("t1_idle_cs", {63'h0, rom_cs}, 64'h1);
    tick();
    chk("t1_pc0", if_pc, 64'h0);
    chk("t1_instr0", {32'h0, if_instr}, 64'h910007E0);
    chk("t1_cnt1", {32'h0, fetch_count}, 64'd1);
    tick();
    chk("t1_pc4", if_pc, 64'h4);
    chk("t1_instr4", {32'h0, if_instr}, 64'h910007E1);
    chk("t1_cnt2", {32'h0, fetch_count}, 64'd2);

    // 2: stall for three cycles with if_pc = 4.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_pc", if_pc, 64'h4);
      chk("t2_instr", {32'h0, if_instr}, 64'h910007E1);
      chk("t2_valid", {63'h0, if_valid}, 64'h1);
      chk("t2_cnt", {32'h0, fetch_count}, 64'd2);
      chk("t2_addr", {32'h0, rom_address}, 64'h8);
    end
    stall = 0;
    tick();
    chk("t2_pc8", if_pc, 64'h8);
    chk("t2_instr8", {32'h0, if_instr}, 64'hF1003C04);
    chk("t2_cnt3", {32'h0, fetch_count}, 64'd3);

    // 3: redirect wins over a simultaneous stall.
    redirect = 1; redirect_pc = 64'h14; stall = 1;
    tick();
    chk("t3_valid0", {63'h0, if_valid}, 64'h0);
    chk("t3_addr", {32'h0, rom_address}, 64'h14);
    chk("t3_pc_hold", if_pc, 64'h8);
    chk("t3_cnt_hold", {32'h0, fetch_count}, 64'd3);
    redirect = 0; stall = 0;
    tick();
    chk("t3_pc14", if_pc, 64'h14);
    chk("t3_instr14", {32'h0, if_instr}, 64'h8B010000);
    chk("t3_cnt4", {32'h0, fetch_count}, 64'd4);

    // 4: misaligned redirect target faults one cycle later; redirects ignored.
    redirect = 1; redirect_pc = 64'h6;
    tick();
    chk("t4_nofault_yet", {63'h0, fetch_fault}, 64'h0);
    chk("t4_addr6", {32'h0, rom_address}, 64'h6);
    redirect_pc = 64'h10;
    for (int i = 0; i < 10; i++) begin
      redirect = ~i[0];
      tick();
      chk("t4_fault", {63'h0, fetch_fault}, 64'h1);
      chk("t4_cs", {63'h0, rom_cs}, 64'h0);
      chk("t4_oe", {63'h0, rom_oe}, 64'h0);
      chk("t4_valid", {63'h0, if_valid}, 64'h0);
      chk("t4_addr_held", {32'h0, rom_address}, 64'h6);
    end
    chk("t4_cnt", {32'h0, fetch_count}, 64'd4);
    redirect = 0;

    // 5: free run off the end of the ROM.
    reset = 1; tick(); reset = 0;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      done = fetch_fault;
    end
    chk("t5_fault_seen", {63'h0, done}, 64'h1);
    chk("t5_cnt9", {32'h0, fetch_count}, 64'd9);
    chk("t5_pc20", if_pc, 64'h20);
    chk("t5_instr20", {32'h0, if_instr}, 64'hD61F03E0);
    chk("t5_valid", {63'h0, if_valid}, 64'h0);
    chk("t5_addr24", {32'h0, rom_address}, 64'h24);

    // 6: reset mid-stall and mid-redirect.
    reset = 1; tick(); reset = 0;
    repeat (3) tick();
    chk("t6_pre_cnt", {32'h0, fetch_count}, 64'd2);
    stall = 1; redirect = 1; redirect_pc = 64'h10; reset = 1;
    tick();
    chk_reset_vals("t6_rst");
    reset = 0; stall = 0; redirect = 0;
    tick();
    chk("t6_idle_valid", {63'h0, if_valid}, 64'h0);
    chk("t6_idle_cnt", {32'h0, fetch_count}, 64'd0);
    tick();
    chk("t6_first_valid", {63'h0, if_valid}, 64'h1);
    chk("t6_first_pc", if_pc, 64'h0);
    chk("t6_first_instr", {32'h0, if_instr}, 64'h910007E0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
